// File: rtl/cpu_pkg.sv
// cpu_pkg: shared bus codes, instruction classes, control-word layout and FSM states
package cpu_pkg;
  typedef enum logic [2:0] {FETCH0, FETCH1, DECODE, EXEC, PAUSE, HALT} state_e;
  typedef enum logic [2:0] {
    CLS_NOP, CLS_MOV, CLS_ALU, CLS_LDI, CLS_JMP, CLS_RS5, CLS_RS6, CLS_HLT
  } cls_e;
  localparam logic [4:0] MID_MEM = 5'd4, MID_AR0 = 5'd7, MID_AR1 = 5'd8, MID_ALU = 5'd18;
  localparam logic [4:0] SID_IR0 = 5'd0, SID_IR1 = 5'd1, SID_AR0 = 5'd7, SID_AR1 = 5'd8;
  localparam logic [4:0] SID_PC0 = 5'd9, SID_PC1 = 5'd10;
  localparam logic [1:0] AMID_PC = 2'd0;
  localparam int ALU_LSB = 15, MID_LSB = 10, SID_LSB = 5, AMID_LSB = 3;
  localparam int PCI_BIT = 2, MEN_BIT = 1, SEN_BIT = 0;
  localparam int CW_USED = 20;
  // Assemble one control word from its fields; bits above CW_USED stay zero.
  function automatic logic [CW_USED-1:0] cw_pack(
    input logic [4:0] alu, input logic [4:0] mid, input logic [4:0] sid,
    input logic [1:0] amid, input logic pci, input logic men, input logic sen);
    return (CW_USED'(alu) << ALU_LSB) | (CW_USED'(mid) << MID_LSB) |
           (CW_USED'(sid) << SID_LSB) | (CW_USED'(amid) << AMID_LSB) |
           (CW_USED'(pci) << PCI_BIT) | (CW_USED'(men) << MEN_BIT) | (CW_USED'(sen) << SEN_BIT);
  endfunction
  localparam logic [CW_USED-1:0] CW_FETCH0 = cw_pack(5'd0, MID_MEM, SID_IR0, AMID_PC, 1'b1, 1'b1, 1'b1);
  localparam logic [CW_USED-1:0] CW_FETCH1 = cw_pack(5'd0, MID_MEM, SID_IR1, AMID_PC, 1'b1, 1'b1, 1'b1);
endpackage

// File: rtl/cu_decode.sv
// cu_decode: maps IR0 to instruction class, index of final execute step and legality
module cu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir0,
  output cls_e       cls,
  output logic [1:0] last,
  output logic       legal,
  output logic [4:0] arg
);
  assign cls   = cls_e'(ir0[7:5]);
  assign last  = (cls == CLS_JMP) ? 2'd3 : 2'd0;
  assign legal = (cls != CLS_RS5) && (cls != CLS_RS6);
  assign arg   = ir0[4:0];
endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer producing a registered control word
// Optional: define CU_ILLEGAL_TRAP_EN to trap classes 101/110 (pulse illegal, enter HALT).
module control_unit
  import cpu_pkg::*;
#(
  parameter int CW_WIDTH = 33
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hlt,
  input  logic [15:0]         instr_data,
  output logic [CW_WIDTH-1:0] control_bus,
  output logic [3:0]          T,
  output logic                halted,
  output logic                illegal
);
  state_e state_q, state_d;
  logic [1:0] step_q, step_d, last;
  logic [CW_WIDTH-1:0] cw_q;
  logic [CW_USED-1:0] word;
  logic [3:0] t_q, t_d;
  logic halted_q, illegal_q, illegal_d, legal, trap, nop_like;
  logic [4:0] arg, ir1_arg;
  logic unused_ir1_hi;
  cls_e cls;
  cu_decode u_dec (.ir0(instr_data[7:0]), .cls(cls), .last(last), .legal(legal), .arg(arg));
  assign ir1_arg = instr_data[12:8];
  assign unused_ir1_hi = ^instr_data[15:13];
`ifdef CU_ILLEGAL_TRAP_EN
  assign trap = !legal;
`else
  assign trap = 1'b0;
`endif
  assign nop_like = (cls == CLS_NOP) || (!legal && !trap);
  // Next state and execute step; hlt only matters at instruction boundaries.
  always_comb begin
    state_d = state_q;
    step_d = 2'd0;
    illegal_d = 1'b0;
    case (state_q)
      FETCH0: state_d = FETCH1;
      FETCH1: state_d = DECODE;
      DECODE: begin
        state_d = (cls == CLS_HLT || trap) ? HALT : nop_like ? (hlt ? PAUSE : FETCH0) : EXEC;
        illegal_d = trap;
      end
      EXEC: begin
        state_d = (step_q != last) ? EXEC : hlt ? PAUSE : FETCH0;
        step_d = (step_q != last) ? step_q + 2'd1 : 2'd0;
      end
      PAUSE: state_d = hlt ? PAUSE : FETCH0;
      default: state_d = HALT;
    endcase
  end
  // Control word for the state being entered, so the register holds it for that whole cycle.
  always_comb begin
    word = '0;
    case (state_d)
      FETCH0: word = CW_FETCH0;
      FETCH1: word = CW_FETCH1;
      EXEC: case (cls)
        CLS_MOV: word = cw_pack(5'd0, ir1_arg, arg, AMID_PC, 1'b0, 1'b1, 1'b1);
        CLS_ALU: word = cw_pack(arg, MID_ALU, ir1_arg, AMID_PC, 1'b0, 1'b1, 1'b1);
        CLS_LDI: word = cw_pack(5'd0, MID_MEM, arg, AMID_PC, 1'b1, 1'b1, 1'b1);
        default: word = cw_pack(5'd0,
          step_d == 2'd2 ? MID_AR0 : step_d == 2'd3 ? MID_AR1 : MID_MEM,
          step_d == 2'd0 ? SID_AR0 : step_d == 2'd1 ? SID_AR1 : step_d == 2'd2 ? SID_PC0 : SID_PC1,
          AMID_PC, step_d == 2'd0, 1'b1, 1'b1);
      endcase
      default: word = '0;
    endcase
    t_d = (state_d == EXEC) ? 4'b0001 << step_d : 4'b0000;
  end
  // State and registered outputs; reset forces the FETCH0 word immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH0;
      step_q <= 2'd0;
      cw_q <= CW_WIDTH'(CW_FETCH0);
      t_q <= 4'b0000;
      halted_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      cw_q <= CW_WIDTH'(word);
      t_q <= t_d;
      halted_q <= (state_d == PAUSE) || (state_d == HALT);
      illegal_q <= illegal_d;
    end
  end
  assign control_bus = cw_q;
  assign T = t_q;
  assign halted = halted_q;
  assign illegal = illegal_q;
endmodule
